// File: rtl/mc_ctrl_if.sv
// Control/flag bundle between the multi-cycle main controller and the datapath.
// The master side is the controller, the slave side is the datapath/IR/ALU.
interface mc_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       Zero;
   logic [2:0] ALUctr;
   logic       ALUSrc;
   logic       ExtOp;
   logic [1:0] RegDst;
   logic [1:0] MemtoReg;
   logic [1:0] NPCOp;
   logic       PCWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       retire;
   logic [2:0] state;

   modport master (
      input  opcode, funct, Zero,
      output ALUctr, ALUSrc, ExtOp, RegDst, MemtoReg, NPCOp,
      output PCWrite, IRWrite, RegWrite, MemWrite, retire, state
   );

   modport slave (
      output opcode, funct, Zero,
      input  ALUctr, ALUSrc, ExtOp, RegDst, MemtoReg, NPCOp,
      input  PCWrite, IRWrite, RegWrite, MemWrite, retire, state
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: IF/ID/EX/MEM/WB sequencing with combinational
// Moore/Mealy outputs decoded from state, opcode, funct and the ALU Zero flag.
module mc_ctrl (
   input  logic          clk,
   input  logic          reset,
   mc_ctrl_if.master     bus
);
   typedef enum logic [2:0] {
      S_IF  = 3'b000,
      S_ID  = 3'b001,
      S_EX  = 3'b010,
      S_MEM = 3'b011,
      S_WB  = 3'b100
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   state_t state_reg, state_next;

   logic is_rsub, is_radd, is_rtype, is_jr;
   logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, goes_ex;

   assign is_radd  = (bus.opcode == OP_RTYPE) && ((bus.funct == FN_ADD) || (bus.funct == FN_ADDU));
   assign is_rsub  = (bus.opcode == OP_RTYPE) && ((bus.funct == FN_SUB) || (bus.funct == FN_SUBU));
   assign is_rtype = is_radd || is_rsub;
   assign is_jr    = (bus.opcode == OP_RTYPE) && (bus.funct == FN_JR);
   assign is_ori   = (bus.opcode == OP_ORI);
   assign is_lui   = (bus.opcode == OP_LUI);
   assign is_lw    = (bus.opcode == OP_LW);
   assign is_sw    = (bus.opcode == OP_SW);
   assign is_beq   = (bus.opcode == OP_BEQ);
   assign is_jal   = (bus.opcode == OP_JAL);
   assign goes_ex  = is_rtype || is_ori || is_lui || is_lw || is_sw || is_beq;

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= S_IF;
      else
         state_reg <= state_next;
   end

   logic [2:0] aluctr;
   logic       alusrc, extop, pcwrite, irwrite, regwrite, memwrite, retire;
   logic [1:0] regdst, memtoreg, npcop;

   always_comb begin
      state_next = S_IF;
      aluctr     = 3'b000;
      alusrc     = 1'b0;
      extop      = 1'b0;
      regdst     = 2'b00;
      memtoreg   = 2'b00;
      npcop      = 2'b00;
      pcwrite    = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      retire     = 1'b0;
      case (state_reg)
         S_IF: begin
            irwrite    = 1'b1;
            pcwrite    = 1'b1;
            state_next = S_ID;
         end
         S_ID: begin
            if (is_jr) begin
               pcwrite = 1'b1;
               npcop   = 2'b11;
               retire  = 1'b1;
            end else if (is_jal) begin
               state_next = S_WB;
            end else if (goes_ex) begin
               state_next = S_EX;
            end else begin
               retire = 1'b1;
            end
         end
         S_EX: begin
            if (is_rsub || is_beq)  aluctr = 3'b001;
            else if (is_ori)        aluctr = 3'b010;
            else if (is_lui)        aluctr = 3'b011;
            alusrc = is_ori || is_lui || is_lw || is_sw;
            extop  = is_lw || is_sw || is_beq;
            if (is_beq) begin
               // Zero comes straight from the ALU in this same cycle
               pcwrite = bus.Zero;
               npcop   = 2'b01;
               retire  = 1'b1;
            end else if (is_lw || is_sw) begin
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            if (is_sw) begin
               memwrite = 1'b1;
               retire   = 1'b1;
            end else begin
               state_next = S_WB;
            end
         end
         S_WB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
            if (is_rtype) begin
               regdst = 2'b01;
            end else if (is_lw) begin
               memtoreg = 2'b01;
            end else if (is_jal) begin
               regdst   = 2'b10;
               memtoreg = 2'b10;
               pcwrite  = 1'b1;
               npcop    = 2'b10;
            end
         end
         default: state_next = S_IF;
      endcase
      // A reset cycle must never produce a partial write or a retire pulse
      if (reset) begin
         aluctr   = 3'b000;
         alusrc   = 1'b0;
         extop    = 1'b0;
         regdst   = 2'b00;
         memtoreg = 2'b00;
         npcop    = 2'b00;
         pcwrite  = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
         memwrite = 1'b0;
         retire   = 1'b0;
      end
   end

   assign bus.ALUctr   = aluctr;
   assign bus.ALUSrc   = alusrc;
   assign bus.ExtOp    = extop;
   assign bus.RegDst   = regdst;
   assign bus.MemtoReg = memtoreg;
   assign bus.NPCOp    = npcop;
   assign bus.PCWrite  = pcwrite;
   assign bus.IRWrite  = irwrite;
   assign bus.RegWrite = regwrite;
   assign bus.MemWrite = memwrite;
   assign bus.retire   = retire;
   assign bus.state    = state_reg;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each cycle's expected controls are queued when
// inputs are driven and checked against the DUT on the following falling edge.
module tb_mc_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mc_ctrl_if bus_i ();
   mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus_i));

   typedef struct packed {
      logic [2:0] st;
      logic [2:0] aluctr;
      logic       alusrc;
      logic       extop;
      logic [1:0] regdst;
      logic [1:0] memtoreg;
      logic [1:0] npcop;
      logic       pcw;
      logic       irw;
      logic       regw;
      logic       memw;
      logic       ret;
   } ctl_t;

   typedef struct {
      ctl_t  exp;
      string tag;
   } sb_t;

   sb_t sb[$];
   int  checks = 0;
   int  passed = 0;

   localparam logic [2:0] IF = 3'd0, ID = 3'd1, EX = 3'd2, MEM = 3'd3, WB = 3'd4;

   function automatic ctl_t mk(logic [2:0] st, logic [2:0] alu, logic asrc, logic ext,
                               logic [1:0] rd, logic [1:0] m2r, logic [1:0] npc,
                               logic pcw, logic irw, logic rw, logic mw, logic ret);
      ctl_t c;
      c = '{st, alu, asrc, ext, rd, m2r, npc, pcw, irw, rw, mw, ret};
      return c;
   endfunction

   function automatic ctl_t quiet(logic [2:0] st);
      return mk(st, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
   endfunction

   function automatic ctl_t fetch();
      return mk(IF, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0);
   endfunction

   ctl_t obs;
   always_comb begin
      obs = mk(bus_i.state, bus_i.ALUctr, bus_i.ALUSrc, bus_i.ExtOp, bus_i.RegDst,
               bus_i.MemtoReg, bus_i.NPCOp, bus_i.PCWrite, bus_i.IRWrite,
               bus_i.RegWrite, bus_i.MemWrite, bus_i.retire);
   end

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         sb_t e;
         e = sb.pop_front();
         checks++;
         assert (obs.st === e.exp.st) passed++;
         else $error("FAIL %s state: got %0d want %0d", e.tag, obs.st, e.exp.st);
         checks++;
         assert (obs === e.exp) passed++;
         else $error("FAIL %s controls: got %h want %h", e.tag, obs, e.exp);
         $display("cycle %-10s state=%0d ctl=%h", e.tag, obs.st, obs);
      end
   end

   task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input ctl_t e, input string tag);
      sb_t s;
      reset        = rst;
      bus_i.opcode = op;
      bus_i.funct  = fn;
      bus_i.Zero   = z;
      s.exp = e;
      s.tag = tag;
      sb.push_back(s);
      @(posedge clk);
      #1;
   endtask

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, ORI = 6'b001101;
   localparam logic [5:0] LUI = 6'b001111, JAL = 6'b000011, R = 6'b000000;

   initial begin
      bus_i.opcode = 6'b111111;
      bus_i.funct  = 6'b0;
      bus_i.Zero   = 1'b0;
      @(posedge clk);
      #1;
      step(1, LW, 0, 0, quiet(IF), "rst_init");
      // lw partially executed, then aborted by a 2-cycle reset
      step(0, LW, 0, 0, fetch(), "lw_a_if");
      step(0, LW, 0, 0, quiet(ID), "lw_a_id");
      step(0, LW, 0, 0, mk(EX, 3'b000, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0), "lw_a_ex");
      step(1, LW, 0, 0, quiet(MEM), "rst_mid0");
      step(1, LW, 0, 0, quiet(IF), "rst_mid1");
      // full lw
      step(0, LW, 0, 0, fetch(), "lw_if");
      step(0, LW, 0, 0, quiet(ID), "lw_id");
      step(0, LW, 0, 0, mk(EX, 3'b000, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0), "lw_ex");
      step(0, LW, 0, 0, quiet(MEM), "lw_mem");
      step(0, LW, 0, 0, mk(WB, 3'b000, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0, 1), "lw_wb");
      // beq taken / not taken
      step(0, BEQ, 0, 1, fetch(), "beq1_if");
      step(0, BEQ, 0, 1, quiet(ID), "beq1_id");
      step(0, BEQ, 0, 1, mk(EX, 3'b001, 0, 1, 2'b00, 2'b00, 2'b01, 1, 0, 0, 0, 1), "beq1_ex");
      step(0, BEQ, 0, 0, fetch(), "beq0_if");
      step(0, BEQ, 0, 0, quiet(ID), "beq0_id");
      step(0, BEQ, 0, 0, mk(EX, 3'b001, 0, 1, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1), "beq0_ex");
      // ori, lui, sub, sw
      step(0, ORI, 0, 1, fetch(), "ori_if");
      step(0, ORI, 0, 1, quiet(ID), "ori_id");
      step(0, ORI, 0, 1, mk(EX, 3'b010, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0), "ori_ex");
      step(0, ORI, 0, 1, mk(WB, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1), "ori_wb");
      step(0, LUI, 0, 0, fetch(), "lui_if");
      step(0, LUI, 0, 0, quiet(ID), "lui_id");
      step(0, LUI, 0, 0, mk(EX, 3'b011, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0), "lui_ex");
      step(0, LUI, 0, 0, mk(WB, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1), "lui_wb");
      step(0, R, 6'b100010, 1, fetch(), "sub_if");
      step(0, R, 6'b100010, 1, quiet(ID), "sub_id");
      step(0, R, 6'b100010, 1, mk(EX, 3'b001, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0), "sub_ex");
      step(0, R, 6'b100010, 1, mk(WB, 3'b000, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 1), "sub_wb");
      step(0, SW, 0, 0, fetch(), "sw_if");
      step(0, SW, 0, 0, quiet(ID), "sw_id");
      step(0, SW, 0, 0, mk(EX, 3'b000, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0), "sw_ex");
      step(0, SW, 0, 0, mk(MEM, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 1), "sw_mem");
      // addu behaves as add
      step(0, R, 6'b100001, 0, fetch(), "addu_if");
      step(0, R, 6'b100001, 0, quiet(ID), "addu_id");
      step(0, R, 6'b100001, 0, mk(EX, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0), "addu_ex");
      step(0, R, 6'b100001, 0, mk(WB, 3'b000, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 1), "addu_wb");
      // jal then jr
      step(0, JAL, 0, 0, fetch(), "jal_if");
      step(0, JAL, 0, 0, quiet(ID), "jal_id");
      step(0, JAL, 0, 0, mk(WB, 3'b000, 0, 0, 2'b10, 2'b10, 2'b10, 1, 0, 1, 0, 1), "jal_wb");
      step(0, R, 6'b001000, 0, fetch(), "jr_if");
      step(0, R, 6'b001000, 0, mk(ID, 3'b000, 0, 0, 2'b00, 2'b00, 2'b11, 1, 0, 0, 0, 1), "jr_id");
      // nop and an unknown opcode
      step(0, R, 6'b000000, 0, fetch(), "nop_if");
      step(0, R, 6'b000000, 0, mk(ID, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1), "nop_id");
      step(0, 6'b111111, 0, 1, fetch(), "unk_if");
      step(0, 6'b111111, 0, 1, mk(ID, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1), "unk_id");
      step(0, LW, 0, 0, fetch(), "end_if");
      @(negedge clk);
      #1;
      checks++;
      assert (sb.size() == 0) passed++;
      else $error("FAIL drain: %0d entries left, want 0", sb.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the CPU datapath. It decodes `opcode`/`funct` from the external instruction register and, one state per clock, drives `ALUctr` and the datapath mux selects and write enables. It consumes the ALU's `Zero` flag for `beq`, so it sits at the other end of the ALU's control/flag interface. Supported instructions: add, addu, sub, subu, ori, lw, sw, beq, lui, jal, jr, nop.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]; stable from ID until the next IF.
- `funct` in 6: IR[5:0].
- `Zero` in 1: ALU result == 0.
- `ALUctr` out 3: 000 add, 001 sub, 010 or, 011 Op2<<16.
- `ALUSrc` out 1: 0 = rt register, 1 = extended immediate.
- `ExtOp` out 1: 0 = zero-extend, 1 = sign-extend.
- `RegDst` out 2: 00 rt, 01 rd, 10 $31.
- `MemtoReg` out 2: 00 ALUOut, 01 MDR, 10 PC (already PC+4).
- `NPCOp` out 2: 00 PC+4, 01 PC+sext(imm)<<2, 10 {PC[31:28],index,00}, 11 rs register.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1 each: write enables.
- `retire` out 1: one-cycle pulse in an instruction's final state.
- `state` out 3: current state, exported for debug.

## Operation
- States: IF=000, ID=001, EX=010, MEM=011, WB=100. Codes 101–111 are illegal and go to IF on the next edge.
- All outputs are combinational from `state`, `opcode`, `funct` and `Zero`. Defaults: every enable 0, `retire` 0, all selects 0.
- IF: `IRWrite`=1, `PCWrite`=1, `NPCOp`=00. Next state ID.
- ID: decode.
  - jr (op 000000, funct 001000): `PCWrite`=1, `NPCOp`=11, `retire`=1; next state IF.
  - jal (op 000011): next state WB.
  - add/addu/sub/subu, ori, lw, sw, lui, beq: next state EX.
  - Anything else, including nop (all-zero word) and unknown codes: `retire`=1; next state IF; no writes.
- EX: `ALUctr` is 000 for add/addu/lw/sw, 001 for sub/subu/beq, 010 for ori, 011 for lui.
  - Immediate forms set `ALUSrc`=1. `ExtOp`=1 for lw/sw/beq and 0 for ori/lui.
  - lw/sw go to MEM. R-type, ori and lui go to WB.
  - beq: `PCWrite`=`Zero`, `NPCOp`=01, `retire`=1; next state IF.
- MEM:
  - sw: `MemWrite`=1, `retire`=1; next state IF.
  - lw: next state WB.
- WB: `RegWrite`=1, `retire`=1; next state IF. Selects per instruction:
  - R-type: `RegDst`=01, `MemtoReg`=00.
  - ori/lui: `RegDst`=00, `MemtoReg`=00.
  - lw: `RegDst`=00, `MemtoReg`=01.
  - jal: `RegDst`=10, `MemtoReg`=10, `PCWrite`=1, `NPCOp`=10.
- Overflow is not trapped; add and addu behave identically.

## Timing
- Cycles per instruction: jr/nop 2; beq/jal 3; R-type/ori/lui/sw 4; lw 5.
- `reset` sampled high at an edge: `state` becomes IF.
- While `reset` is high, `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` and `retire` are forced 0 and `ALUctr`/selects read 0. The first cycle after deassertion is IF with `PCWrite`=`IRWrite`=1.
- Reset mid-instruction (any state) aborts it. No partial write occurs in the reset cycle, and `retire` does not pulse.
- `Zero` is used only in EX of beq. It must settle in that same cycle; no registering.
- `retire` is high for exactly one cycle per instruction and is never high in IF.

## Test plan
- Reset held 2 cycles from an arbitrary state, then released -> `state`=000, all enables 0 during reset; next cycle `IRWrite`=`PCWrite`=1.
- lw (op 100011) -> states 0,1,2,3,4. In EX: `ALUctr`=000, `ALUSrc`=1, `ExtOp`=1. In WB: `RegWrite`=1, `MemtoReg`=01. `retire` only in WB.
- beq with `Zero`=1, then with `Zero`=0 -> EX shows `ALUctr`=001, `NPCOp`=01, `PCWrite`=1 then 0. Both take 3 cycles.
- Sequence ori, lui, sub (funct 100010), sw -> `ALUctr` 010, 011, 001, 000 in the respective EX cycles. `MemWrite` pulses once, in MEM of sw.
- jal then jr -> jal WB: `RegDst`=10, `MemtoReg`=10, `NPCOp`=10, `PCWrite`=1. jr ID: `NPCOp`=11, `PCWrite`=1. Total 5 cycles.
- Word 0x00000000, then opcode 111111 -> each takes IF→ID→IF with no write enables. `retire` pulses in ID.
